// File: rtl/memory_controller_pkg.sv
// Shared types and opcode constants for the byte-serial memory controller.
// Imported by the controller, its bus interface and the testbench.
package memory_controller_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_LOAD  = 2'd2,
        ST_STORE = 2'd3
    } state_e;

    localparam logic [5:0] OP_LB  = 6'd1;
    localparam logic [5:0] OP_LH  = 6'd2;
    localparam logic [5:0] OP_LW  = 6'd3;
    localparam logic [5:0] OP_LBU = 6'd4;
    localparam logic [5:0] OP_LHU = 6'd5;
    localparam logic [5:0] OP_SB  = 6'd6;
    localparam logic [5:0] OP_SH  = 6'd7;
    localparam logic [5:0] OP_SW  = 6'd8;

    // Index of the last byte of an access: transfer length minus one.
    function automatic logic [1:0] op_last(input logic [5:0] op);
        logic [1:0] last;
        case (op)
            OP_LB, OP_LBU, OP_SB: last = 2'd0;
            OP_LH, OP_LHU, OP_SH: last = 2'd1;
            default:              last = 2'd3;
        endcase
        return last;
    endfunction

endpackage

// File: rtl/memory_controller_if.sv
// Requester and RAM/IO bus signals of the memory controller.
// The slave modport is the controller side; master is the environment side.
interface memory_controller_if;
    import memory_controller_pkg::*;

    logic        lsb_request;
    logic        lsb_load_or_store;
    logic [5:0]  lsb_op;
    logic [31:0] lsb_addr;
    logic [31:0] lsb_data;
    logic        lsb_mem_valid;
    logic [31:0] lsb_mem_val;
    logic        if_request;
    logic [31:0] if_addr;
    logic        if_valid;
    logic [31:0] if_inst;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full;

    modport master (
        output lsb_request, lsb_load_or_store, lsb_op, lsb_addr, lsb_data,
        output if_request, if_addr, mem_din, io_buffer_full,
        input  lsb_mem_valid, lsb_mem_val, if_valid, if_inst,
        input  mem_dout, mem_a, mem_wr
    );

    modport slave (
        input  lsb_request, lsb_load_or_store, lsb_op, lsb_addr, lsb_data,
        input  if_request, if_addr, mem_din, io_buffer_full,
        output lsb_mem_valid, lsb_mem_val, if_valid, if_inst,
        output mem_dout, mem_a, mem_wr
    );

endinterface

// File: rtl/memory_controller.sv
// Byte-serial memory controller: arbitrates LSB and fetch requests and
// sequences 1/2/4-byte transfers on the single-port 8-bit RAM/IO bus.
module memory_controller
    import memory_controller_pkg::*;
#(
    parameter logic [31:0] IO_BASE = 32'h0003_0000
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              clear,
    memory_controller_if.slave bus
);

    state_e      state_r;
    logic [1:0]  cnt_r;
    logic [1:0]  last_r;
    logic        rx_en_r;
    logic [5:0]  op_r;
    logic [31:0] addr_r;
    logic [31:0] data_r;
    logic [31:0] asm_r;
    logic        lsb_valid_r;
    logic [31:0] lsb_val_r;
    logic        if_valid_r;
    logic [31:0] if_inst_r;
    logic [7:0]  mem_dout_r;
    logic [31:0] mem_a_r;
    logic        mem_wr_r;

    logic [31:0] asm_next_s;
    logic [2:0]  iss_idx_s;
    logic        more_iss_s;
    logic [1:0]  st_idx_s;
    logic [31:0] st_addr_s;
    logic [7:0]  st_byte_s;
    logic        st_stall_s;
    logic        accept_s;

    function automatic logic is_io(input logic [31:0] a);
        return a[17:16] == IO_BASE[17:16];
    endfunction

    function automatic logic [31:0] extend_load(input logic [5:0] op, input logic [31:0] w);
        logic [31:0] r;
        case (op)
            OP_LB:   r = {{24{w[7]}}, w[7:0]};
            OP_LH:   r = {{16{w[15]}}, w[15:0]};
            OP_LBU:  r = {24'd0, w[7:0]};
            OP_LHU:  r = {16'd0, w[15:0]};
            default: r = w;
        endcase
        return r;
    endfunction

    // Byte assembly, issue tracking and next store byte selection
    always_comb begin
        asm_next_s = asm_r;
        asm_next_s[{cnt_r, 3'b000} +: 8] = bus.mem_din;
        if (rx_en_r) begin
            iss_idx_s = {1'b0, cnt_r} + 3'd1;
        end else begin
            iss_idx_s = 3'd0;
        end
        more_iss_s = iss_idx_s < {1'b0, last_r};
        // A stalled store byte is retried; a written one advances.
        if (mem_wr_r) begin
            st_idx_s = cnt_r + 2'd1;
        end else begin
            st_idx_s = cnt_r;
        end
        st_addr_s  = addr_r + {30'd0, st_idx_s};
        st_byte_s  = data_r[{st_idx_s, 3'b000} +: 8];
        st_stall_s = is_io(st_addr_s) && bus.io_buffer_full;
        // No arbitration during a flush or while a done pulse is still out.
        accept_s   = !clear && !lsb_valid_r && !if_valid_r;
    end

    // Access sequencer with all bus and requester outputs registered
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 2'd0;
            last_r      <= 2'd0;
            rx_en_r     <= 1'b0;
            op_r        <= 6'd0;
            addr_r      <= 32'd0;
            data_r      <= 32'd0;
            asm_r       <= 32'd0;
            lsb_valid_r <= 1'b0;
            lsb_val_r   <= 32'd0;
            if_valid_r  <= 1'b0;
            if_inst_r   <= 32'd0;
            mem_dout_r  <= 8'd0;
            mem_a_r     <= 32'd0;
            mem_wr_r    <= 1'b0;
        end else if (rdy_in) begin
            lsb_valid_r <= 1'b0;
            if_valid_r  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    cnt_r   <= 2'd0;
                    rx_en_r <= 1'b0;
                    asm_r   <= 32'd0;
                    if (accept_s && bus.lsb_request) begin
                        op_r    <= bus.lsb_op;
                        addr_r  <= bus.lsb_addr;
                        data_r  <= bus.lsb_data;
                        last_r  <= op_last(bus.lsb_op);
                        mem_a_r <= bus.lsb_addr;
                        if (bus.lsb_load_or_store) begin
                            state_r    <= ST_STORE;
                            mem_dout_r <= bus.lsb_data[7:0];
                            mem_wr_r   <= !(is_io(bus.lsb_addr) && bus.io_buffer_full);
                        end else begin
                            state_r  <= ST_LOAD;
                            mem_wr_r <= 1'b0;
                        end
                    end else if (accept_s && bus.if_request) begin
                        state_r  <= ST_FETCH;
                        op_r     <= OP_LW;
                        addr_r   <= bus.if_addr;
                        last_r   <= 2'd3;
                        mem_a_r  <= bus.if_addr;
                        mem_wr_r <= 1'b0;
                    end else begin
                        mem_a_r  <= 32'd0;
                        mem_wr_r <= 1'b0;
                    end
                end
                ST_LOAD, ST_FETCH: begin
                    mem_wr_r <= 1'b0;
                    if (clear) begin
                        state_r <= ST_IDLE;
                        mem_a_r <= 32'd0;
                        cnt_r   <= 2'd0;
                        rx_en_r <= 1'b0;
                    end else begin
                        if (more_iss_s) begin
                            mem_a_r <= mem_a_r + 32'd1;
                        end
                        // Data lags the address by one cycle, so capture starts in step 1.
                        if (rx_en_r) begin
                            asm_r <= asm_next_s;
                            if (cnt_r == last_r) begin
                                state_r <= ST_IDLE;
                                mem_a_r <= 32'd0;
                                cnt_r   <= 2'd0;
                                rx_en_r <= 1'b0;
                                if (state_r == ST_FETCH) begin
                                    if_valid_r <= 1'b1;
                                    if_inst_r  <= asm_next_s;
                                end else begin
                                    lsb_valid_r <= 1'b1;
                                    lsb_val_r   <= extend_load(op_r, asm_next_s);
                                end
                            end else begin
                                cnt_r <= cnt_r + 2'd1;
                            end
                        end else begin
                            rx_en_r <= 1'b1;
                        end
                    end
                end
                ST_STORE: begin
                    if (mem_wr_r && (cnt_r == last_r)) begin
                        state_r     <= ST_IDLE;
                        mem_wr_r    <= 1'b0;
                        mem_a_r     <= 32'd0;
                        mem_dout_r  <= 8'd0;
                        cnt_r       <= 2'd0;
                        lsb_valid_r <= 1'b1;
                        lsb_val_r   <= 32'd0;
                    end else begin
                        cnt_r      <= st_idx_s;
                        mem_a_r    <= st_addr_s;
                        mem_dout_r <= st_byte_s;
                        mem_wr_r   <= !st_stall_s;
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    mem_wr_r <= 1'b0;
                    mem_a_r  <= 32'd0;
                    cnt_r    <= 2'd0;
                    rx_en_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.lsb_mem_valid = lsb_valid_r;
    assign bus.lsb_mem_val   = lsb_val_r;
    assign bus.if_valid      = if_valid_r;
    assign bus.if_inst       = if_inst_r;
    assign bus.mem_dout      = mem_dout_r;
    assign bus.mem_a         = mem_a_r;
    assign bus.mem_wr        = mem_wr_r;

endmodule

// File: tb/tb_memory_controller.sv
// Scoreboard testbench for memory_controller: expected pulses, writes and
// address samples are queued at stimulus time and checked as the DUT acts.
module tb_memory_controller;
    import memory_controller_pkg::*;

    logic clk_in = 1'b0;
    logic rst_in;
    logic rdy_in;
    logic clear;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    memory_controller_if bus();

    memory_controller #(.IO_BASE(32'h0003_0000)) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .rdy_in (rdy_in),
        .clear  (clear),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc <= cyc + 1;

    typedef struct { logic [31:0] val;  int cyc; } pulse_t;
    typedef struct { logic [31:0] addr; logic [7:0] data; int cyc; } wr_t;

    pulse_t lsb_q[$];
    pulse_t if_q[$];
    wr_t    wr_q[$];
    wr_t    a_q[$];
    pulse_t pe;
    wr_t    we;

    // RAM/IO bus model: one-cycle read latency, frozen with the rest of the system
    logic [7:0]  ram [0:65535];
    logic        pl_en = 1'b0;
    logic [15:0] pl_addr;
    logic [7:0]  pl_data;
    always @(posedge clk_in) begin
        if (pl_en) begin
            ram[pl_addr] <= pl_data;
        end else if (rdy_in) begin
            bus.mem_din <= ram[bus.mem_a[15:0]];
            if (bus.mem_wr) ram[bus.mem_a[15:0]] <= bus.mem_dout;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic sync();
        @(posedge clk_in);
        #1;
    endtask

    task automatic poke(input logic [15:0] a, input logic [7:0] d);
        pl_addr = a; pl_data = d; pl_en = 1'b1;
        sync();
        pl_en = 1'b0;
    endtask

    task automatic exp_lsb(input logic [31:0] v, input int c);
        pulse_t p; p.val = v; p.cyc = c; lsb_q.push_back(p);
    endtask
    task automatic exp_if(input logic [31:0] v, input int c);
        pulse_t p; p.val = v; p.cyc = c; if_q.push_back(p);
    endtask
    task automatic exp_wr(input logic [31:0] a, input logic [7:0] d, input int c);
        wr_t w; w.addr = a; w.data = d; w.cyc = c; wr_q.push_back(w);
    endtask
    task automatic exp_addr(input logic [31:0] a, input int c);
        wr_t w; w.addr = a; w.data = 8'd0; w.cyc = c; a_q.push_back(w);
    endtask

    task automatic lsb_go(input logic ls, input logic [5:0] op, input logic [31:0] a, input logic [31:0] d);
        logic seen = 1'b0;
        bus.lsb_load_or_store = ls; bus.lsb_op = op; bus.lsb_addr = a; bus.lsb_data = d;
        bus.lsb_request = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_in);
            if (bus.lsb_mem_valid && rdy_in) begin seen = 1'b1; break; end
        end
        if (!seen) check_val("lsb_timeout", 32'd0, 32'd1);
        sync();
        bus.lsb_request = 1'b0;
    endtask

    task automatic if_go(input logic [31:0] a);
        logic seen = 1'b0;
        bus.if_addr = a;
        bus.if_request = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_in);
            if (bus.if_valid && rdy_in) begin seen = 1'b1; break; end
        end
        if (!seen) check_val("if_timeout", 32'd0, 32'd1);
        sync();
        bus.if_request = 1'b0;
    endtask

    // Monitor: compares pulses, writes and address samples against the queues
    initial forever begin
        @(negedge clk_in);
        if (rdy_in && !rst_in) begin
            if (bus.lsb_mem_valid) begin
                if (lsb_q.size() == 0) check_val("lsb_extra", 32'd1, 32'd0);
                else begin
                    pe = lsb_q.pop_front();
                    check_val("lsb_val", bus.lsb_mem_val, pe.val);
                    check_val("lsb_cyc", 32'(cyc), 32'(pe.cyc));
                end
            end
            if (bus.if_valid) begin
                if (if_q.size() == 0) check_val("if_extra", 32'd1, 32'd0);
                else begin
                    pe = if_q.pop_front();
                    check_val("if_inst", bus.if_inst, pe.val);
                    check_val("if_cyc", 32'(cyc), 32'(pe.cyc));
                end
            end
            if (bus.mem_wr) begin
                if (wr_q.size() == 0) check_val("wr_extra", bus.mem_a, 32'hFFFF_FFFF);
                else begin
                    we = wr_q.pop_front();
                    check_val("wr_addr", bus.mem_a, we.addr);
                    check_val("wr_data", {24'd0, bus.mem_dout}, {24'd0, we.data});
                    check_val("wr_cyc", 32'(cyc), 32'(we.cyc));
                end
            end
            if (a_q.size() != 0 && a_q[0].cyc == cyc) begin
                we = a_q.pop_front();
                check_val("mem_a", bus.mem_a, we.addr);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        rst_in = 1'b1; rdy_in = 1'b1; clear = 1'b0;
        bus.lsb_request = 1'b0; bus.lsb_load_or_store = 1'b0; bus.lsb_op = 6'd0;
        bus.lsb_addr = 32'd0; bus.lsb_data = 32'd0;
        bus.if_request = 1'b0; bus.if_addr = 32'd0; bus.io_buffer_full = 1'b0;
        poke(16'h1000, 8'h78); poke(16'h1001, 8'h56); poke(16'h1002, 8'h34); poke(16'h1003, 8'h12);
        poke(16'h2003, 8'h80); poke(16'h3000, 8'h00); poke(16'h3001, 8'h80);
        poke(16'hFFFE, 8'h11); poke(16'hFFFF, 8'h22); poke(16'h0000, 8'h33); poke(16'h0001, 8'h44);
        poke(16'h4000, 8'h93); poke(16'h4001, 8'h00); poke(16'h4002, 8'hA0); poke(16'h4003, 8'h00);
        @(negedge clk_in);
        check_val("rst_valid", {30'd0, bus.lsb_mem_valid, bus.if_valid}, 32'd0);
        check_val("rst_val", bus.lsb_mem_val, 32'd0);
        check_val("rst_inst", bus.if_inst, 32'd0);
        check_val("rst_mem_a", bus.mem_a, 32'd0);
        check_val("rst_wr", {24'd0, bus.mem_dout} | {31'd0, bus.mem_wr}, 32'd0);
        sync();
        rst_in = 1'b0;

        // Lw with address trace
        sync(); s = cyc;
        exp_lsb(32'h1234_5678, s + 6);
        for (int k = 0; k < 4; k++) exp_addr(32'h1000 + 32'(k), s + 1 + k);
        lsb_go(1'b0, OP_LW, 32'h1000, 32'd0);
        // Sub-word loads and extension
        sync(); s = cyc; exp_lsb(32'hFFFF_FF80, s + 3); lsb_go(1'b0, OP_LB,  32'h2003, 32'd0);
        sync(); s = cyc; exp_lsb(32'h0000_0080, s + 3); lsb_go(1'b0, OP_LBU, 32'h2003, 32'd0);
        sync(); s = cyc; exp_lsb(32'hFFFF_8000, s + 4); lsb_go(1'b0, OP_LH,  32'h3000, 32'd0);
        sync(); s = cyc; exp_lsb(32'h0000_8000, s + 4); lsb_go(1'b0, OP_LHU, 32'h3000, 32'd0);
        // Lw wrapping across 2^32
        sync(); s = cyc; exp_lsb(32'h4433_2211, s + 6); exp_addr(32'h0, s + 3);
        lsb_go(1'b0, OP_LW, 32'hFFFF_FFFE, 32'd0);
        // Sw then read back
        sync(); s = cyc;
        exp_wr(32'h100, 8'hEF, s + 1); exp_wr(32'h101, 8'hBE, s + 2);
        exp_wr(32'h102, 8'hAD, s + 3); exp_wr(32'h103, 8'hDE, s + 4);
        exp_lsb(32'd0, s + 5);
        lsb_go(1'b1, OP_SW, 32'h100, 32'hDEAD_BEEF);
        sync(); s = cyc; exp_lsb(32'hDEAD_BEEF, s + 6); lsb_go(1'b0, OP_LW, 32'h100, 32'd0);
        // Sh to non-IO address ignores a full UART buffer
        sync(); s = cyc; bus.io_buffer_full = 1'b1;
        exp_wr(32'h204, 8'hFE, s + 1); exp_wr(32'h205, 8'hCA, s + 2); exp_lsb(32'd0, s + 3);
        lsb_go(1'b1, OP_SH, 32'h204, 32'h0000_CAFE);
        // Sb to IO with buffer full for 3 cycles
        sync(); s = cyc; bus.io_buffer_full = 1'b1;
        exp_wr(32'h3_0000, 8'h5A, s + 4); exp_lsb(32'd0, s + 5);
        fork
            lsb_go(1'b1, OP_SB, 32'h3_0000, 32'h0000_005A);
            begin sync(); sync(); sync(); bus.io_buffer_full = 1'b0; end
        join
        // Simultaneous requests: LSB first, fetch right after its pulse
        sync(); s = cyc;
        exp_lsb(32'h1234_5678, s + 6); exp_addr(32'h1000, s + 1); exp_addr(32'h4000, s + 8);
        exp_if(32'h00A0_0093, s + 13);
        fork
            lsb_go(1'b0, OP_LW, 32'h1000, 32'd0);
            if_go(32'h4000);
        join
        // Clear in cycle 2 of an Lw aborts it
        sync(); s = cyc; exp_addr(32'h0, s + 3);
        bus.lsb_load_or_store = 1'b0; bus.lsb_op = OP_LW; bus.lsb_addr = 32'h1000; bus.lsb_request = 1'b1;
        sync(); sync(); clear = 1'b1; bus.lsb_request = 1'b0;
        sync(); clear = 1'b0;
        repeat (8) sync();
        // Clear in IDLE defers acceptance by one cycle
        sync(); s = cyc; clear = 1'b1; exp_lsb(32'h0000_0080, s + 4);
        fork
            lsb_go(1'b0, OP_LBU, 32'h2003, 32'd0);
            begin sync(); clear = 1'b0; end
        join
        // Clear during Sw: store commits
        sync(); s = cyc;
        exp_wr(32'h100, 8'h04, s + 1); exp_wr(32'h101, 8'h03, s + 2);
        exp_wr(32'h102, 8'h02, s + 3); exp_wr(32'h103, 8'h01, s + 4);
        exp_lsb(32'd0, s + 5);
        fork
            lsb_go(1'b1, OP_SW, 32'h100, 32'h0102_0304);
            begin sync(); sync(); clear = 1'b1; sync(); clear = 1'b0; end
        join
        // rdy_in low for 2 cycles mid-Lh
        sync(); s = cyc; exp_lsb(32'hFFFF_8000, s + 6);
        fork
            lsb_go(1'b0, OP_LH, 32'h3000, 32'd0);
            begin sync(); sync(); rdy_in = 1'b0; sync(); sync(); rdy_in = 1'b1; end
        join
        // Reset mid-fetch
        sync();
        bus.if_addr = 32'h4000; bus.if_request = 1'b1;
        sync(); sync(); rst_in = 1'b1; bus.if_request = 1'b0;
        sync(); rst_in = 1'b0;
        @(negedge clk_in);
        check_val("rst_fetch_mem_a", bus.mem_a, 32'd0);
        check_val("rst_fetch_inst", bus.if_inst, 32'd0);
        check_val("rst_fetch_flags", {29'd0, bus.if_valid, bus.lsb_mem_valid, bus.mem_wr}, 32'd0);
        repeat (8) sync();

        check_val("lsb_q_left", 32'(lsb_q.size()), 32'd0);
        check_val("if_q_left", 32'(if_q.size()), 32'd0);
        check_val("wr_q_left", 32'(wr_q.size()), 32'd0);
        check_val("a_q_left", 32'(a_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
